// File: rtl/ysyx_220066_pkg.sv
// Shared memory-op encodings and responder FSM state type.
package ysyx_220066_pkg;

    // MemOp: bit 2 selects zero-extension, bits 1:0 select the access size.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    localparam int unsigned OP_ZEXT_BIT = 2;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } mem_state_e;

endpackage

// File: rtl/ysyx_220066_mem_resp_if.sv
// Request/response handshake bundle between the core data port and the responder.
interface ysyx_220066_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [2:0]  req_op;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_op, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_op, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_220066_lane_unit.sv
// Byte-lane logic: load extract/extend, store mask/replicate/merge, alignment check.
module ysyx_220066_lane_unit
    import ysyx_220066_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [2:0]  lane,
    input  logic [63:0] old_word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word,
    output logic [7:0]  wmask,
    output logic        bad
);

    logic [63:0] shifted;
    logic [63:0] rep;
    logic        zext;
    logic        misaligned;

    // Load path: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        shifted = old_word >> {lane, 3'b000};
        zext    = op[OP_ZEXT_BIT];
        unique case (op[1:0])
            SZ_B: load_data = zext ? {56'b0, shifted[7:0]}
                                   : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = zext ? {48'b0, shifted[15:0]}
                                   : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = zext ? {32'b0, shifted[31:0]}
                                   : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = old_word;
        endcase
    end

    // Store path: replicate data to every lane, pick lanes by mask, merge with old word.
    always_comb begin
        unique case (op[1:0])
            SZ_B: begin
                rep   = {8{wdata[7:0]}};
                wmask = 8'h01 << lane;
            end
            SZ_H: begin
                rep   = {4{wdata[15:0]}};
                wmask = 8'h03 << {lane[2:1], 1'b0};
            end
            SZ_W: begin
                rep   = {2{wdata[31:0]}};
                wmask = 8'h0f << {lane[2], 2'b00};
            end
            default: begin
                rep   = wdata;
                wmask = 8'hff;
            end
        endcase
        store_word = old_word;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                store_word[i*8 +: 8] = rep[i*8 +: 8];
            end
        end
    end

    // Natural alignment per size; op 111 is never legal.
    always_comb begin
        unique case (op[1:0])
            SZ_H:    misaligned = lane[0];
            SZ_W:    misaligned = |lane[1:0];
            SZ_D:    misaligned = |lane;
            default: misaligned = 1'b0;
        endcase
        bad = misaligned || (op == OP_ILLEGAL);
    end

endmodule

// File: rtl/ysyx_220066_mem_resp.sv
// Stalling data-memory responder: one request at a time, fixed latency, 64-bit array.
module ysyx_220066_mem_resp
    import ysyx_220066_pkg::*;
#(
    parameter logic [63:0] BASE  = 64'h8000_0000,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned LAT   = 2
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_220066_mem_resp_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    mem_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic [63:0]   addr_q;
    logic [2:0]    op_q;
    logic [63:0]   wdata_q;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic [63:0]   rdata_q;
    logic          err_q;

    logic [63:0]   mem [DEPTH];

    logic [63:0]   off;
    logic [IW-1:0] idx;
    logic          range_err;
    logic          lane_bad;
    logic          acc_err;
    logic          access;
    logic          do_write;
    logic [63:0]   old_word;
    logic [63:0]   load_data;
    logic [63:0]   store_word;
    logic [7:0]    wmask;

    // Word index and range check; a below-BASE address wraps, so test it separately.
    always_comb begin
        off       = addr_q - BASE;
        idx       = off[IW+2:3];
        range_err = (addr_q < BASE) || (off[63:IW+3] != '0);
        old_word  = mem[idx];
        acc_err   = range_err || lane_bad;
        access    = (state_q == StBusy) && (cnt_q == '0);
        do_write  = access && wr_q && !acc_err;
    end

    ysyx_220066_lane_unit u_lane (
        .op         (op_q),
        .lane       (addr_q[2:0]),
        .old_word   (old_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .wmask      (wmask),
        .bad        (lane_bad)
    );

    // Array write; no reset so contents survive rst. Reset forces StIdle, cancelling writes.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= store_word;
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            op_q         <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_wr;
                        addr_q      <= bus.req_addr;
                        op_q        <= bus.req_op;
                        wdata_q     <= bus.req_wdata;
                        cnt_q       <= CNT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        err_q        <= acc_err;
                        rdata_q      <= (acc_err || wr_q) ? 64'd0 : load_data;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_220066_mem_resp.sv
// Scoreboard bench for the stalling memory responder.
module tb_ysyx_220066_mem_resp;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ysyx_220066_mem_resp_if bus ();

    ysyx_220066_mem_resp #(
        .BASE  (64'h8000_0000),
        .DEPTH (4096),
        .LAT   (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one request (called #1 after a posedge), collect its response, complete handshake.
    task automatic transact(input logic wr, input logic [63:0] addr, input logic [2:0] op,
                            input logic [63:0] wdata, output logic [63:0] rdata,
                            output logic err, output int lat);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_addr   = addr;
        bus.req_op     = op;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.resp_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout addr=%h got resp_valid=%b want 1", addr, bus.resp_valid);
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_op = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.resp_err); end
    endtask

    // Stimulus table: wr, addr, op, wdata and the expected response.
    task automatic run_table(input string name, input logic wr_t[], input logic [63:0] addr_t[],
                             input logic [2:0] op_t[], input logic [63:0] wd_t[],
                             input logic [63:0] er_t[], input logic ee_t[]);
        logic [63:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        for (int i = 0; i < addr_t.size(); i++) begin
            exp_q.push_back('{rdata: er_t[i], err: ee_t[i]});
            transact(wr_t[i], addr_t[i], op_t[i], wd_t[i], rd, er, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (rd !== e.rdata) begin
                n_bad++;
                $display("FAIL %s[%0d]_rdata got %h want %h", name, i, rd, e.rdata);
            end
            n_cmp++;
            if (er !== e.err) begin
                n_bad++;
                $display("FAIL %s[%0d]_err got %b want %b", name, i, er, e.err);
            end
            n_cmp++;
            if (lat !== LAT) begin
                n_bad++;
                $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, LAT);
            end
        end
    endtask

    task automatic test_loads();
        run_table("loads",
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{64'h8000_0000, 64'h8000_0007, 64'h8000_0002, 64'h8000_0004,
              64'h8000_0007, 64'h8000_0006, 64'h8000_0004},
            '{3'b011, 3'b000, 3'b101, 3'b010, 3'b100, 3'b001, 3'b110},
            '{64'h8877_6655_4433_2211, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
            '{64'd0, 64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_4433,
              64'hFFFF_FFFF_8877_6655, 64'h0000_0000_0000_0088,
              64'hFFFF_FFFF_FFFF_8877, 64'h0000_0000_8877_6655},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_store_merge();
        run_table("merge",
            '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
            '{64'h8000_0006, 64'h8000_0000, 64'h8000_0001, 64'h8000_0000,
              64'h8000_0004, 64'h8000_0000},
            '{3'b001, 3'b011, 3'b000, 3'b011, 3'b110, 3'b011},
            '{64'hABCD, 64'd0, 64'h5A, 64'd0, 64'h1234_5678_CAFE_F00D, 64'd0},
            '{64'd0, 64'hABCD_6655_4433_2211, 64'd0, 64'hABCD_6655_4433_5A11,
              64'd0, 64'hCAFE_F00D_4433_5A11},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_errors();
        run_table("errors",
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{64'h8000_0002, 64'h8000_7FF8, 64'h7FFF_FFF8, 64'h8000_7FF8,
              64'h8000_8000, 64'h8000_0000, 64'h8000_0004, 64'h8000_0000, 64'h8000_0001},
            '{3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b011, 3'b011, 3'b001},
            '{64'd0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
              64'd0, 64'd0, 64'h1111_1111_1111_1111, 64'd0, 64'd0},
            '{64'd0, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0,
              64'hCAFE_F00D_4433_5A11, 64'd0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        exp_q.push_back('{rdata: 64'h0000_0000_0000_5A11, err: 1'b0});
        exp_q.push_back('{rdata: 64'h0000_0000_0000_00CA, err: 1'b0});
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 64'h8000_0000;
        bus.req_op = 3'b001; bus.req_wdata = '0;
        @(posedge clk); #1;
        // Second request stays pending while the first is in flight.
        bus.req_addr = 64'h8000_0007; bus.req_op = 3'b100;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        e = exp_q.pop_front();
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata || bus.resp_err !== e.err) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b want v=1 d=%h e=%b", i,
                         bus.resp_valid, bus.resp_rdata, bus.resp_err, e.rdata, e.err);
            end
            n_cmp++;
            if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, bus.req_ready); end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_hs_valid got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_hs_ready got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        e = exp_q.pop_front();
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL bp2_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (bus.resp_rdata !== e.rdata) begin n_bad++; $display("FAIL bp2_rdata got %h want %h", bus.resp_rdata, e.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        logic [63:0] rd;
        logic        er;
        int          lat;
        run_table("rb_pre",
            '{1'b1, 1'b0},
            '{64'h8000_0010, 64'h8000_0010},
            '{3'b011, 3'b011},
            '{64'hDEAD_BEEF_0000_1234, 64'd0},
            '{64'd0, 64'hDEAD_BEEF_0000_1234},
            '{1'b0, 1'b0});
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 64'h8000_0010;
        bus.req_op = 3'b011; bus.req_wdata = 64'h1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rb_req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rb_resp_valid got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_rdata !== 64'd0) begin n_bad++; $display("FAIL rb_rdata got %h want 0", bus.resp_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back('{rdata: 64'hDEAD_BEEF_0000_1234, err: 1'b0});
        transact(1'b0, 64'h8000_0010, 3'b011, 64'd0, rd, er, lat);
        n_cmp++;
        if (rd !== exp_q[0].rdata) begin
            n_bad++;
            $display("FAIL rb_old_contents got %h want %h", rd, exp_q[0].rdata);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_merge();
        test_errors();
        test_backpressure();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
